prewish_poll_sched: RTL and testbench
=====================================

# prewish_poll_sched

Polling scheduler for the button-status responder: periodically issues a one-cycle status request over the STB handshake, waits with a bounded timeout for the response strobe, and latches the returned status byte. It converts successive snapshots into per-bit press/release event pulses, so downstream logic (mask entry, LED pattern select) never handshakes with the status block directly. It sits between the status responder and the application logic, one instance per responder.

## Interface
- POLL_PERIOD, 12000 — cycles between poll requests (1 kHz at 12 MHz); must be ≥ 2
- POLL_BITS, 14 — width of poll timer; must hold POLL_PERIOD-1
- TIMEOUT, 8 — max cycles spent in WAIT before abandoning a poll; must be ≥ 1
- TIMEOUT_BITS, 4 — width of timeout counter; must hold TIMEOUT-1

- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = polling allowed; sampled only in IDLE
- i_clr_err  in  1  synchronous clear of o_timeout
- STB_O  out  1  request strobe to responder, one-cycle pulse
- STB_I  in  1  response strobe from responder, one-cycle pulse
- DAT_I  in  8  response status byte, valid when STB_I = 1
- o_state  out  8  last accepted status byte, active high
- o_pressed  out  8  bits that went 0→1 in last update, one-cycle pulse
- o_released  out  8  bits that went 1→0 in last update, one-cycle pulse
- o_evt_stb  out  1  one-cycle pulse, high iff o_pressed|o_released ≠ 0
- o_timeout  out  1  sticky: a poll timed out
- o_alive  out  1  toggles on every accepted response

## Operation
- States: IDLE, REQ, WAIT, UPDATE (2-bit encoding; unused codes → IDLE).
- IDLE: poll timer loaded POLL_PERIOD-1 on entry; decrements while ≠ 0. When timer = 0 and i_enable = 1 → REQ. With timer = 0 and i_enable = 0, stay in IDLE with timer held at 0.
- REQ: STB_O = 1 for this cycle only; timeout counter cleared → WAIT.
- WAIT: STB_O = 0. STB_I = 1 → capture DAT_I into response register → UPDATE. Otherwise, if timeout counter = TIMEOUT-1 → set o_timeout → IDLE; else increment the counter.
- UPDATE: register o_pressed = resp & ~o_state, o_released = ~resp & o_state, o_state = resp, o_evt_stb = |(pressed|released), toggle o_alive → IDLE.
- STB_I outside WAIT is ignored (no capture, no events).
- i_clr_err clears o_timeout. A timeout in the same cycle as i_clr_err takes priority, so o_timeout ends at 1.
- A timed-out poll leaves o_state unchanged and generates no events.

## Timing
- Reset (RST_I = 0, async): state IDLE, poll timer POLL_PERIOD-1, STB_O 0, o_state 8'h00, o_pressed/o_released 8'h00, o_evt_stb 0, o_timeout 0, o_alive 0. Reset mid-handshake abandons the poll. A late STB_I after reset release is ignored.
- First STB_O after reset release with i_enable = 1: POLL_PERIOD cycles after the first active edge.
- Poll interval with prompt responses: POLL_PERIOD + 2 + W + 1 cycles, where W = WAIT cycles before STB_I.
- STB_I sampled high on edge N → o_state/o_pressed/o_released/o_evt_stb valid from edge N+1 for one cycle (o_state persists).
- Event outputs are 0 in every cycle except the one following UPDATE.
- Timeout: if no STB_I, WAIT lasts exactly TIMEOUT cycles; o_timeout rises at the edge ending the last WAIT cycle.
- STB_O is never high in two consecutive cycles, and never high while in WAIT.

## Configuration
- PREWISH_POLL_TIMEOUT_EN defined: timeout counter and o_timeout behave as above.
- Not defined: no timeout counter; WAIT holds indefinitely until STB_I. o_timeout is tied to 0, and TIMEOUT/TIMEOUT_BITS are unused.

## Test plan
- Reset, i_enable = 1, POLL_PERIOD = 10, responder model answers STB_I 3 cycles after STB_O with 8'h00 → first STB_O at cycle 10; o_evt_stb stays 0; o_alive toggles each poll.
- Response 8'h05 after 8'h00 → o_pressed = 8'h05, o_released = 8'h00, o_evt_stb = 1 for one cycle; o_state = 8'h05. Next response 8'h04 → o_released = 8'h01, o_pressed = 8'h00.
- No responder, TIMEOUT = 8 (macro on) → WAIT lasts 8 cycles, then o_timeout = 1 and o_state is unchanged. i_clr_err pulse → o_timeout = 0. Macro off → FSM stays in WAIT; a later STB_I is accepted normally.
- Spurious STB_I with DAT_I = 8'hFF while in IDLE → no change to o_state and no events.
- i_enable = 0 for 3×POLL_PERIOD → STB_O never asserted. Raising i_enable → STB_O on the next cycle.
- Assert RST_I low during WAIT → all outputs return to reset values asynchronously; the first STB_O follows POLL_PERIOD cycles after release.

Source files
------------

// File: rtl/prewish_poll_sched.sv
// Polling scheduler for the button-status responder: periodic STB request, response capture, press/release events.
// Optional macro PREWISH_POLL_TIMEOUT_EN adds a bounded WAIT with a sticky o_timeout flag.
module prewish_poll_sched #(
  parameter int POLL_PERIOD  = 12000,
  parameter int POLL_BITS    = 14,
  parameter int TIMEOUT      = 8,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_enable,
  input  logic       i_clr_err,
  output logic       STB_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_state,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_evt_stb,
  output logic       o_timeout,
  output logic       o_alive
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  localparam logic [POLL_BITS-1:0] PollReload = POLL_BITS'(POLL_PERIOD - 1);

  state_e               state_q, state_d;
  logic [POLL_BITS-1:0] timer_q, timer_d;
  logic [7:0]           resp_q, resp_d;
  logic [7:0]           status_q, status_d;
  logic [7:0]           pressed_q, pressed_d;
  logic [7:0]           released_q, released_d;
  logic                 evt_q, evt_d;
  logic                 alive_q, alive_d;
  logic                 timeout_q, timeout_d;
  logic                 timeout_hit;

`ifdef PREWISH_POLL_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] TmoLast = TIMEOUT_BITS'(TIMEOUT - 1);
  logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    resp_d      = resp_q;
    status_d    = status_q;
    pressed_d   = 8'h00;
    released_d  = 8'h00;
    evt_d       = 1'b0;
    alive_d     = alive_q;
    timeout_hit = 1'b0;
`ifdef PREWISH_POLL_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Timer parks at zero while disabled so a later enable requests immediately.
        if (timer_q != '0) begin
          timer_d = timer_q - POLL_BITS'(1);
        end else if (i_enable) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef PREWISH_POLL_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (STB_I) begin
          resp_d  = DAT_I;
          state_d = S_UPDATE;
        end
`ifdef PREWISH_POLL_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
          timer_d     = PollReload;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
        end
`endif
      end
      S_UPDATE: begin
        pressed_d  = resp_q & ~status_q;
        released_d = ~resp_q & status_q;
        evt_d      = |(resp_q ^ status_q);
        status_d   = resp_q;
        alive_d    = ~alive_q;
        state_d    = S_IDLE;
        timer_d    = PollReload;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = PollReload;
      end
    endcase
    // A timeout in the same cycle as a clear wins; without the macro this flop stays at 0.
    timeout_d = timeout_hit | (timeout_q & ~i_clr_err);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      timer_q    <= PollReload;
      resp_q     <= 8'h00;
      status_q   <= 8'h00;
      pressed_q  <= 8'h00;
      released_q <= 8'h00;
      evt_q      <= 1'b0;
      alive_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      status_q   <= status_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      evt_q      <= evt_d;
      alive_q    <= alive_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PREWISH_POLL_TIMEOUT_EN
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign STB_O      = (state_q == S_REQ);
  assign o_state    = status_q;
  assign o_pressed  = pressed_q;
  assign o_released = released_q;
  assign o_evt_stb  = evt_q;
  assign o_timeout  = timeout_q;
  assign o_alive    = alive_q;

endmodule

// File: tb/tb_prewish_poll_sched.sv
// Bench for prewish_poll_sched: timestamp-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_prewish_poll_sched;
  localparam int P  = 10;
  localparam int PB = 4;
  localparam int T  = 8;
  localparam int TB = 3;
`ifdef PREWISH_POLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       stb_i = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic       stb_o, evt, tmo, alive;
  logic [7:0] st, pr, rl;

  always #5 clk = ~clk;

  prewish_poll_sched #(.POLL_PERIOD(P), .POLL_BITS(PB), .TIMEOUT(T), .TIMEOUT_BITS(TB)) dut (
    .CLK_I(clk), .RST_I(rst_n), .i_enable(en), .i_clr_err(clr),
    .STB_O(stb_o), .STB_I(stb_i), .DAT_I(dat_i),
    .o_state(st), .o_pressed(pr), .o_released(rl),
    .o_evt_stb(evt), .o_timeout(tmo), .o_alive(alive)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute edge timestamps instead of a state machine.
  int         e_cnt, next_poll, req_edge;
  bit         busy, upd_due;
  logic [7:0] m_resp;
  logic [7:0] x_state, x_pressed, x_released;
  bit         x_evt, x_stb, x_tmo, x_alive;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt = 0; next_poll = P; req_edge = -10; busy = 0; upd_due = 0; m_resp = 8'h00;
      x_state = 8'h00; x_pressed = 8'h00; x_released = 8'h00;
      x_evt = 0; x_stb = 0; x_tmo = 0; x_alive = 0;
    end else begin
      bit tmo_now;
      tmo_now = 0;
      e_cnt++;
      x_pressed = 8'h00; x_released = 8'h00; x_evt = 0; x_stb = 0;
      if (upd_due) begin
        x_pressed  = m_resp & ~x_state;
        x_released = ~m_resp & x_state;
        x_evt      = (m_resp != x_state);
        x_state    = m_resp;
        x_alive    = !x_alive;
        upd_due    = 0;
        next_poll  = e_cnt + P;
      end else if (busy) begin
        // Edge req_edge+1 leaves the request cycle; responses count from the next edge on.
        if (e_cnt > req_edge + 1) begin
          if (stb_i) begin
            m_resp = dat_i; upd_due = 1; busy = 0;
          end else if (TO_EN && (e_cnt - req_edge - 1 == T)) begin
            tmo_now = 1; busy = 0; next_poll = e_cnt + P;
          end
        end
      end else if (e_cnt >= next_poll && en) begin
        busy = 1; req_edge = e_cnt; x_stb = 1;
      end
      x_tmo = tmo_now || (x_tmo && !clr);
    end
  end

  always @(negedge clk) begin
    check("stb_o", 32'(stb_o), 32'(x_stb));
    check("o_state", 32'(st), 32'(x_state));
    check("o_pressed", 32'(pr), 32'(x_pressed));
    check("o_released", 32'(rl), 32'(x_released));
    check("o_evt_stb", 32'(evt), 32'(x_evt));
    check("o_timeout", 32'(tmo), 32'(x_tmo));
    check("o_alive", 32'(alive), 32'(x_alive));
  end

  // Responder and random stimulus, advanced one falling edge at a time.
  bit         rand_mode = 0, rsp_on = 0, spur_on = 0;
  int         rsp_delay = 3, rsp_cnt = 0;
  logic [7:0] rsp_data = 8'h00;

  task automatic tick();
    @(negedge clk);
    stb_i = 1'b0;
    clr   = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin stb_i = 1'b1; dat_i = rsp_data; end
    end else if (stb_o) begin
      if (rand_mode) begin
        rsp_on    = ($urandom_range(0, 3) != 0);
        rsp_delay = $urandom_range(0, T + 2);
        rsp_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (rsp_data ^ 8'(1 << $urandom_range(0, 7)));
      end
      if (rsp_on) begin
        if (rsp_delay == 0) begin stb_i = 1'b1; dat_i = rsp_data; end
        else rsp_cnt = rsp_delay;
      end
    end else if (spur_on && $urandom_range(0, 15) == 0) begin
      stb_i = 1'b1;
      dat_i = 8'($urandom);
    end
    if (rand_mode) begin
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) en = !en;
    end
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    do begin tick(); n++; end while (!stb_o && n < 200);
    if (!stb_o) begin
      checks++; errors++;
      $display("FAIL wait_stb: no STB_O after %0d cycles, required within 200", n);
    end
  endtask

  task automatic wait_evt(output int n);
    n = 0;
    do begin tick(); n++; end while (!evt && n < 200);
    if (!evt) begin
      checks++; errors++;
      $display("FAIL wait_evt: no o_evt_stb after %0d cycles, required within 200", n);
    end
  endtask

  initial begin
    int n, cnt;
    logic [7:0] exp_st;
    rst_n = 1'b0; en = 1'b1; rsp_on = 1; rsp_delay = 3; rsp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(st), 32'h00);
    check("reset_stb", 32'(stb_o), 32'h0);
    #2 rst_n = 1'b1;

    // First request P cycles after release; responses 3 cycles after STB_O give interval P+2+W+1 with W=2.
    wait_stb(n);
    check("first_stb_cycle", 32'(n), 32'd10);
    wait_stb(n);
    check("poll_interval", 32'(n), 32'd15);
    check("alive_after_first", 32'(alive), 32'h1);
    check("state_after_zero", 32'(st), 32'h00);

    rsp_data = 8'h05;
    wait_evt(n);
    check("evt_latency", 32'(n), 32'd5);
    check("press_05", 32'(pr), 32'h05);
    check("release_05", 32'(rl), 32'h00);
    check("state_05", 32'(st), 32'h05);
    tick();
    check("evt_one_cycle", 32'(evt), 32'h0);
    check("state_persist", 32'(st), 32'h05);

    rsp_data = 8'h04;
    wait_evt(n);
    check("press_04", 32'(pr), 32'h00);
    check("release_04", 32'(rl), 32'h01);
    check("state_04", 32'(st), 32'h04);

    rsp_on = 0;
    wait_stb(n);
    repeat (T) tick();
    check("timeout_not_yet", 32'(tmo), 32'h0);
    tick();
`ifdef PREWISH_POLL_TIMEOUT_EN
    check("timeout_set", 32'(tmo), 32'h1);
    check("timeout_state_kept", 32'(st), 32'h04);
    clr = 1'b1;
    tick();
    check("timeout_cleared", 32'(tmo), 32'h0);
    exp_st = 8'h04;
`else
    cnt = 0;
    repeat (3 * P) begin tick(); if (stb_o) cnt++; end
    check("wait_holds_no_stb", 32'(cnt), 32'd0);
    check("wait_holds_tmo", 32'(tmo), 32'h0);
    stb_i = 1'b1; dat_i = 8'hA5;
    tick();
    tick();
    check("late_resp_state", 32'(st), 32'hA5);
    check("late_resp_press", 32'(pr), 32'hA1);
    check("late_resp_release", 32'(rl), 32'h00);
    exp_st = 8'hA5;
`endif

    stb_i = 1'b1; dat_i = 8'hFF;
    tick();
    tick();
    check("spurious_state", 32'(st), 32'(exp_st));
    check("spurious_evt", 32'(evt), 32'h0);

    en = 1'b0;
    cnt = 0;
    repeat (3 * P) begin tick(); if (stb_o) cnt++; end
    check("disabled_no_stb", 32'(cnt), 32'd0);
    rsp_on = 0;
    en = 1'b1;
    tick();
    check("enable_rise_stb", 32'(stb_o), 32'h1);

    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(st), 32'h00);
    check("async_rst_alive", 32'(alive), 32'h0);
    check("async_rst_stb", 32'(stb_o), 32'h0);
    check("async_rst_evt", 32'(evt), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stb_i = 1'b1; dat_i = 8'hFF;
    rsp_on = 1; rsp_delay = 3;
    wait_stb(n);
    check("stb_after_reset", 32'(n), 32'd10);
    check("late_stb_ignored", 32'(st), 32'h00);

    rand_mode = 1; spur_on = 1;
    repeat (3000) tick();
    rand_mode = 0; spur_on = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
